// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment scanner with dwell/gap timing,
// frame-synchronous value updates, blanking, decimal points and leading-zero suppression.
module seg7_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int DIGIT_CYCLES   = 100000,
  parameter int GAP_CYCLES     = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp,
  input  logic [N_DIGITS-1:0]     blank,
  input  logic                    load,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp_o,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_tick
);

  localparam int MAXC = (DIGIT_CYCLES > GAP_CYCLES) ? DIGIT_CYCLES : GAP_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int NS   = 1 << IW;

  localparam logic [CW-1:0] DLAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] GLAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] ILAST = IW'(N_DIGITS - 1);
  localparam logic          SEG_POL = (SEG_ACTIVE_LOW != 0);
  localparam logic          AN_POL  = (AN_ACTIVE_LOW != 0);

  typedef enum logic {ST_GAP, ST_SHOW} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0]   shadow_val_q, shadow_val_d;
  logic [N_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic [N_DIGITS-1:0]     shadow_blank_q, shadow_blank_d;
  logic [4*N_DIGITS-1:0]   pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0]     pend_blank_q, pend_blank_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [N_DIGITS-1:0]     an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_o_q, dp_o_d;
  logic                    frame_tick_q, frame_tick_d;

  logic                    wrap;
  logic [3:0]              nib [NS];
  logic [NS-1:0]           dp_sel_v, blank_sel_v, on_v;
  logic [N_DIGITS-1:0]     an_hot;
  logic [N_DIGITS:0]       nz_above;
  logic [N_DIGITS-1:0]     lit_an;
  logic [6:0]              lit_seg;
  logic                    lit_dp;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0: g = 7'h7E;  4'h1: g = 7'h30;  4'h2: g = 7'h6D;  4'h3: g = 7'h79;
      4'h4: g = 7'h33;  4'h5: g = 7'h5B;  4'h6: g = 7'h5F;  4'h7: g = 7'h70;
      4'h8: g = 7'h7F;  4'h9: g = 7'h7B;  4'hA: g = 7'h77;  4'hB: g = 7'h1F;
      4'hC: g = 7'h4E;  4'hD: g = 7'h3D;  4'hE: g = 7'h4F;  default: g = 7'h47;
    endcase
    return g;
  endfunction

  // Per-digit lookup tables padded to a power of two so idx_q indexes them exactly.
  assign nz_above[N_DIGITS] = 1'b0;
  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_slot
      if (gi < N_DIGITS) begin : g_real
        assign nib[gi]         = shadow_val_q[4*gi +: 4];
        assign nz_above[gi]    = (|shadow_val_q[4*gi +: 4]) | nz_above[gi+1];
        assign on_v[gi]        = (gi == 0) || !lz_en || nz_above[gi];
        assign dp_sel_v[gi]    = shadow_dp_q[gi];
        assign blank_sel_v[gi] = shadow_blank_q[gi];
        assign an_hot[gi]      = (idx_q == IW'(gi));
      end else begin : g_pad
        assign nib[gi]         = 4'h0;
        assign on_v[gi]        = 1'b0;
        assign dp_sel_v[gi]    = 1'b0;
        assign blank_sel_v[gi] = 1'b1;
      end
    end
  endgenerate

  assign wrap = (state_q == ST_SHOW) && (idx_q == ILAST) && (cnt_q == DLAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_GAP: begin
        if (GAP_CYCLES == 0 || cnt_q == GLAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == DLAST) begin
          idx_d   = (idx_q == ILAST) ? '0 : idx_q + 1'b1;
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? ST_SHOW : ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // A load coinciding with the wrap bypasses pending and lands in the next frame directly.
  always_comb begin
    pend_val_d     = pend_val_q;
    pend_dp_d      = pend_dp_q;
    pend_blank_d   = pend_blank_q;
    pend_valid_d   = pend_valid_q;
    shadow_val_d   = shadow_val_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp;
      pend_blank_d = blank;
      pend_valid_d = 1'b1;
    end
    if (wrap) begin
      if (load) begin
        shadow_val_d   = value;
        shadow_dp_d    = dp;
        shadow_blank_d = blank;
      end else begin
        pend_valid_d = 1'b0;
        if (pend_valid_q) begin
          shadow_val_d   = pend_val_q;
          shadow_dp_d    = pend_dp_q;
          shadow_blank_d = pend_blank_q;
        end
      end
    end
  end

  always_comb begin
    lit_an  = '0;
    lit_seg = '0;
    lit_dp  = 1'b0;
    if (state_q == ST_SHOW) begin
      lit_an = an_hot;
      if (!blank_sel_v[idx_q] && on_v[idx_q]) begin
        lit_seg = glyph(nib[idx_q]);
      end
      lit_dp = dp_sel_v[idx_q] & ~blank_sel_v[idx_q];
    end
    an_d         = lit_an ^ {N_DIGITS{AN_POL}};
    seg_d        = lit_seg ^ {7{SEG_POL}};
    dp_o_d       = lit_dp ^ SEG_POL;
    frame_tick_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_GAP;
      idx_q          <= '0;
      cnt_q          <= '0;
      shadow_val_q   <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      pend_val_q     <= '0;
      pend_dp_q      <= '0;
      pend_blank_q   <= '0;
      pend_valid_q   <= 1'b0;
      an_q           <= {N_DIGITS{AN_POL}};
      seg_q          <= {7{SEG_POL}};
      dp_o_q         <= SEG_POL;
      frame_tick_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      shadow_val_q   <= shadow_val_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      pend_val_q     <= pend_val_d;
      pend_dp_q      <= pend_dp_d;
      pend_blank_q   <= pend_blank_d;
      pend_valid_q   <= pend_valid_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_o_q         <= dp_o_d;
      frame_tick_q   <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_o       = dp_o_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit gapped active-low instance and a 2-digit
// gapless active-high instance, each checked against a frame-slot reference model.
module tb_seg7_scan_driver;

  localparam logic [6:0] GLYPH [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  localparam int A_FL = 4 * (4 + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] a_value = '0;
  logic [3:0]  a_dp = '0, a_blank = '0;
  logic        a_load = 1'b0, a_lz = 1'b0;
  logic [6:0]  a_seg;
  logic        a_dpo, a_ft;
  logic [3:0]  a_an;

  logic [7:0]  b_value = '0;
  logic [1:0]  b_dp = '0, b_blank = '0;
  logic        b_load = 1'b0, b_lz = 1'b0;
  logic [6:0]  b_seg;
  logic        b_dpo, b_ft;
  logic [1:0]  b_an;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(.N_DIGITS(4), .DIGIT_CYCLES(4), .GAP_CYCLES(1),
                     .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst(rst), .value(a_value), .dp(a_dp), .blank(a_blank), .load(a_load),
    .lz_en(a_lz), .seg(a_seg), .dp_o(a_dpo), .an(a_an), .frame_tick(a_ft));

  seg7_scan_driver #(.N_DIGITS(2), .DIGIT_CYCLES(3), .GAP_CYCLES(0),
                     .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst(rst), .value(b_value), .dp(b_dp), .blank(b_blank), .load(b_load),
    .lz_en(b_lz), .seg(b_seg), .dp_o(b_dpo), .an(b_an), .frame_tick(b_ft));

  // Reference: cycle k after reset release maps to a slot in the frame timeline.
  function automatic void predict(input int n, input int d, input int g, input int k,
                                  input logic [31:0] v, input logic [7:0] dpm,
                                  input logic [7:0] blm, input logic lz,
                                  output logic [7:0] an_l, output logic [6:0] seg_l,
                                  output logic dp_l, output logic wr);
    int fl, eff, s, dig, ph;
    logic [31:0] hi;
    logic [3:0] nb;
    an_l = '0; seg_l = '0; dp_l = 1'b0; wr = 1'b0;
    fl  = n * (d + g);
    eff = (g == 0) ? k - 1 : k;
    if (eff < 0) return;
    s   = eff % fl;
    dig = s / (d + g);
    ph  = s % (d + g);
    if (ph < g) return;
    wr = (s == fl - 1);
    an_l[dig] = 1'b1;
    hi = v >> (4 * dig);
    nb = v[4*dig +: 4];
    if (!blm[dig] && !(lz && dig > 0 && hi == 0)) seg_l = GLYPH[nb];
    dp_l = dpm[dig] & ~blm[dig];
  endfunction

  int          ka, kb;
  logic [15:0] sa_v, pa_v;
  logic [3:0]  sa_dp, sa_bl, pa_dp, pa_bl;
  logic        pa_ok;
  logic [3:0]  ea_an;
  logic [6:0]  ea_seg;
  logic        ea_dp, ea_ft;
  logic [7:0]  sb_v, pb_v;
  logic [1:0]  sb_dp, sb_bl, pb_dp, pb_bl;
  logic        pb_ok;
  logic [1:0]  eb_an;
  logic [6:0]  eb_seg;
  logic        eb_dp, eb_ft;

  always @(posedge clk) begin : model_a
    logic [7:0] an_l; logic [6:0] seg_l; logic dp_l, wr;
    if (rst) begin
      ka = 0; sa_v = '0; sa_dp = '0; sa_bl = '0; pa_v = '0; pa_dp = '0; pa_bl = '0; pa_ok = 1'b0;
      ea_an = 4'hF; ea_seg = 7'h7F; ea_dp = 1'b1; ea_ft = 1'b0;
    end else begin
      predict(4, 4, 1, ka, {16'h0, sa_v}, {4'h0, sa_dp}, {4'h0, sa_bl}, a_lz, an_l, seg_l, dp_l, wr);
      ea_an = an_l[3:0] ^ 4'hF; ea_seg = seg_l ^ 7'h7F; ea_dp = ~dp_l; ea_ft = wr;
      if (wr) begin
        if (a_load) begin sa_v = a_value; sa_dp = a_dp; sa_bl = a_blank; end
        else if (pa_ok) begin sa_v = pa_v; sa_dp = pa_dp; sa_bl = pa_bl; end
      end
      if (a_load) begin pa_v = a_value; pa_dp = a_dp; pa_bl = a_blank; pa_ok = 1'b1; end
      else if (wr) pa_ok = 1'b0;
      ka++;
    end
  end

  always @(posedge clk) begin : model_b
    logic [7:0] an_l; logic [6:0] seg_l; logic dp_l, wr;
    if (rst) begin
      kb = 0; sb_v = '0; sb_dp = '0; sb_bl = '0; pb_v = '0; pb_dp = '0; pb_bl = '0; pb_ok = 1'b0;
      eb_an = 2'b00; eb_seg = 7'h00; eb_dp = 1'b0; eb_ft = 1'b0;
    end else begin
      predict(2, 3, 0, kb, {24'h0, sb_v}, {6'h0, sb_dp}, {6'h0, sb_bl}, b_lz, an_l, seg_l, dp_l, wr);
      eb_an = an_l[1:0]; eb_seg = seg_l; eb_dp = dp_l; eb_ft = wr;
      if (wr) begin
        if (b_load) begin sb_v = b_value; sb_dp = b_dp; sb_bl = b_blank; end
        else if (pb_ok) begin sb_v = pb_v; sb_dp = pb_dp; sb_bl = pb_bl; end
      end
      if (b_load) begin pb_v = b_value; pb_dp = b_dp; pb_bl = b_blank; pb_ok = 1'b1; end
      else if (wr) pb_ok = 1'b0;
      kb++;
    end
  end

  task automatic test_reset();
    $display("test_reset: reset with a colliding load");
    rst = 1'b1; a_load = 1'b1; a_value = 16'hFFFF; b_load = 1'b1; b_value = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({a_an, a_seg, a_dpo, a_ft} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_a an=%b seg=%h dp=%b ft=%b want an=1111 seg=7f dp=1 ft=0", a_an, a_seg, a_dpo, a_ft);
      end
      checks++;
      if ({b_an, b_seg, b_dpo, b_ft} !== {2'b00, 7'h00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_b an=%b seg=%h dp=%b ft=%b want an=00 seg=00 dp=0 ft=0", b_an, b_seg, b_dpo, b_ft);
      end
    end
    a_load = 1'b0; b_load = 1'b0; a_value = '0; b_value = '0;
    rst = 1'b0;
    // Load during reset is discarded: the first frame shows "0" on digit 0.
    repeat (A_FL + 2) begin
      @(negedge clk);
      checks++;
      if ({a_an, a_seg, a_dpo, a_ft} !== {ea_an, ea_seg, ea_dp, ea_ft}) begin
        errors++;
        $display("FAIL post_reset an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                 a_an, a_seg, a_dpo, a_ft, ea_an, ea_seg, ea_dp, ea_ft);
      end
    end
  endtask

  task automatic test_first_frame();
    int last_ft, gap_seen;
    $display("test_first_frame: load 1234");
    a_value = 16'h1234; a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    last_ft = -1; gap_seen = 0;
    for (int c = 0; c < 3 * A_FL; c++) begin
      @(negedge clk);
      checks++;
      if ({a_an, a_seg, a_dpo, a_ft} !== {ea_an, ea_seg, ea_dp, ea_ft}) begin
        errors++;
        $display("FAIL frame_1234 an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                 a_an, a_seg, a_dpo, a_ft, ea_an, ea_seg, ea_dp, ea_ft);
      end
      if (a_ft) begin
        if (last_ft >= 0) begin
          checks++;
          if (c - last_ft !== 20) begin
            errors++;
            $display("FAIL frame_tick_period got %0d want 20", c - last_ft);
          end
        end
        last_ft = c;
      end
      if (a_an === 4'b1110 && c >= 2 * A_FL) begin
        checks++;
        if (a_seg !== 7'h4C) begin
          errors++;
          $display("FAIL digit0_glyph4 got %h want 4c", a_seg);
        end
      end
      if (a_an === 4'b1111) gap_seen++;
    end
    checks++;
    if (gap_seen < 3 * 4 - 1) begin
      errors++;
      $display("FAIL dark_gaps got %0d want >= 11", gap_seen);
    end
  endtask

  task automatic test_midframe_load();
    $display("test_midframe_load: load ABCD mid-frame");
    while ((ka % A_FL) != 8) @(negedge clk);
    a_value = 16'hABCD; a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    repeat (2 * A_FL) begin
      @(negedge clk);
      checks++;
      if ({a_an, a_seg, a_dpo, a_ft} !== {ea_an, ea_seg, ea_dp, ea_ft}) begin
        errors++;
        $display("FAIL midframe an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                 a_an, a_seg, a_dpo, a_ft, ea_an, ea_seg, ea_dp, ea_ft);
      end
    end
  endtask

  task automatic test_wrap_load();
    $display("test_wrap_load: load 00F0 on the wrap cycle with lz_en");
    while ((ka % A_FL) != A_FL - 1) @(negedge clk);
    a_value = 16'h00F0; a_load = 1'b1; a_lz = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    repeat (A_FL + 2) begin
      @(negedge clk);
      checks++;
      if ({a_an, a_seg, a_dpo, a_ft} !== {ea_an, ea_seg, ea_dp, ea_ft}) begin
        errors++;
        $display("FAIL wrap_load an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                 a_an, a_seg, a_dpo, a_ft, ea_an, ea_seg, ea_dp, ea_ft);
      end
      if (a_an === 4'b1101) begin
        checks++;
        if (a_seg !== 7'h38) begin errors++; $display("FAIL lz_digit1 got %h want 38", a_seg); end
      end
      if (a_an === 4'b0111 || a_an === 4'b1011) begin
        checks++;
        if (a_seg !== 7'h7F) begin errors++; $display("FAIL lz_suppressed got %h want 7f", a_seg); end
      end
    end
  endtask

  task automatic test_blank_dp();
    $display("test_blank_dp: blank=0100 dp=0101");
    a_lz = 1'b0; a_value = 16'h5678; a_blank = 4'b0100; a_dp = 4'b0101; a_load = 1'b1;
    @(negedge clk);
    a_load = 1'b0;
    repeat (2 * A_FL) begin
      @(negedge clk);
      checks++;
      if ({a_an, a_seg, a_dpo, a_ft} !== {ea_an, ea_seg, ea_dp, ea_ft}) begin
        errors++;
        $display("FAIL blank_dp an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                 a_an, a_seg, a_dpo, a_ft, ea_an, ea_seg, ea_dp, ea_ft);
      end
    end
    a_blank = '0; a_dp = '0;
  endtask

  task automatic test_random();
    $display("test_random: random loads, dp, blank, lz_en");
    for (int c = 0; c < 300; c++) begin
      a_load  = ($urandom_range(0, 7) == 0);
      a_value = 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom);
      a_dp    = 4'($urandom);
      a_blank = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
      if ($urandom_range(0, 31) == 0) a_lz = ~a_lz;
      @(negedge clk);
      checks++;
      if ({a_an, a_seg, a_dpo, a_ft} !== {ea_an, ea_seg, ea_dp, ea_ft}) begin
        errors++;
        $display("FAIL random an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                 a_an, a_seg, a_dpo, a_ft, ea_an, ea_seg, ea_dp, ea_ft);
      end
    end
    a_load = 1'b0;
  endtask

  task automatic test_reset_midshow();
    $display("test_reset_midshow: reset during digit 2");
    a_value = 16'h9876; a_load = 1'b1; a_lz = 1'b0;
    @(negedge clk);
    a_load = 1'b0;
    repeat (A_FL) @(negedge clk);
    while ((ka % A_FL) != 12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({a_an, a_seg, a_dpo, a_ft} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_midshow an=%b seg=%h dp=%b ft=%b want an=1111 seg=7f dp=1 ft=0", a_an, a_seg, a_dpo, a_ft);
    end
    repeat (A_FL + 2) begin
      @(negedge clk);
      checks++;
      if ({a_an, a_seg, a_dpo, a_ft} !== {ea_an, ea_seg, ea_dp, ea_ft}) begin
        errors++;
        $display("FAIL restart an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                 a_an, a_seg, a_dpo, a_ft, ea_an, ea_seg, ea_dp, ea_ft);
      end
      if (a_an === 4'b1110) begin
        checks++;
        if (a_seg !== 7'h01) begin errors++; $display("FAIL restart_zero got %h want 01", a_seg); end
      end
    end
  endtask

  task automatic test_no_gap();
    int dark;
    $display("test_no_gap: 2-digit gapless active-high instance");
    dark = 0;
    for (int c = 0; c < 120; c++) begin
      b_load  = ($urandom_range(0, 5) == 0);
      b_value = 8'($urandom);
      b_dp    = 2'($urandom);
      b_blank = 2'($urandom_range(0, 3) == 0 ? $urandom : 0);
      b_lz    = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({b_an, b_seg, b_dpo, b_ft} !== {eb_an, eb_seg, eb_dp, eb_ft}) begin
        errors++;
        $display("FAIL no_gap an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b",
                 b_an, b_seg, b_dpo, b_ft, eb_an, eb_seg, eb_dp, eb_ft);
      end
      if (b_an === 2'b00) dark++;
    end
    b_load = 1'b0;
    checks++;
    if (dark !== 0) begin errors++; $display("FAIL no_gap_dark got %0d dark cycles want 0", dark); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_midframe_load();
    test_wrap_load();
    test_blank_dp();
    test_random();
    test_reset_midshow();
    test_no_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
